// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared timing constants and types for the raster generator
package video_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CW       = 10;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } ctrl_state_e;

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FP,
      PH_SYNC,
      PH_BP
   } axis_phase_e;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } pixel_t;

endpackage

// File: rtl/video_axis_counter.sv
// rtl/video_axis_counter.sv - one raster axis: wrapping counter with phase decode
module video_axis_counter
   import video_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP,
   parameter int CW     = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cnt_en_i,
   output logic          wrap_o,
   output logic [CW-1:0] count_o,
   output axis_phase_e   phase_o,
   output logic          sync_o
);

   localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
   localparam logic [CW-1:0] FP_END   = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);
   localparam logic [CW-1:0] LAST     = CW'(ACTIVE + FP + SYNC + BP - 1);

   logic [CW-1:0] count_q, count_d;

   assign wrap_o  = cnt_en_i && (count_q == LAST);
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (cnt_en_i) begin
         count_d = wrap_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_comb begin
      phase_o = PH_BP;
      if (count_q < ACT_END) begin
         phase_o = PH_ACTIVE;
      end else if (count_q < FP_END) begin
         phase_o = PH_FP;
      end else if (count_q < SYNC_END) begin
         phase_o = PH_SYNC;
      end
   end

   assign sync_o = (phase_o == PH_SYNC);

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster timing generator pulling pixels from an upstream source
module video_timing_ctrl
   import video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = 1,
   parameter int CW       = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [8:0]    pixel_data,
   input  logic          pixel_valid,
   output logic          pixel_ready,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          blank,
   output logic [2:0]    red,
   output logic [2:0]    green,
   output logic [2:0]    blue,
   output logic          frame_start,
   output logic          underflow,
   input  logic          underflow_clr
);

   localparam logic SYNC_ON = (SYNC_POL != 0);

   ctrl_state_e   state_q, state_d;
   logic          run;
   logic          h_wrap, v_wrap, h_sync, v_sync;
   logic [CW-1:0] h_count, v_count;
   axis_phase_e   h_phase, v_phase;
   pixel_t        pixel_in;

   logic   hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
   logic   frame_start_q, frame_start_d, underflow_q, underflow_d;
   pixel_t rgb_q, rgb_d;

   assign run = (state_q == ST_RUN);

   video_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
   ) u_h_axis (
      .clk(clk), .reset(reset), .cnt_en_i(run), .wrap_o(h_wrap),
      .count_o(h_count), .phase_o(h_phase), .sync_o(h_sync)
   );

   video_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
   ) u_v_axis (
      .clk(clk), .reset(reset), .cnt_en_i(h_wrap), .wrap_o(v_wrap),
      .count_o(v_count), .phase_o(v_phase), .sync_o(v_sync)
   );

   // v_wrap marks the last clock of a frame, the only point enable is honoured in RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable) state_d = ST_RUN;
         ST_RUN:  if (v_wrap && !enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign pixel_ready = run && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
   assign x           = pixel_ready ? h_count : '0;
   assign y           = pixel_ready ? v_count : '0;
   assign pixel_in    = pixel_t'(pixel_data);

   always_comb begin
      hsync_d       = (run && h_sync) ? SYNC_ON : ~SYNC_ON;
      vsync_d       = (run && v_sync) ? SYNC_ON : ~SYNC_ON;
      blank_d       = !pixel_ready;
      rgb_d         = (pixel_ready && pixel_valid) ? pixel_in : '0;
      frame_start_d = pixel_ready && (h_count == '0) && (v_count == '0);
      underflow_d   = (pixel_ready && !pixel_valid) || (underflow_q && !underflow_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         hsync_q       <= ~SYNC_ON;
         vsync_q       <= ~SYNC_ON;
         blank_q       <= 1'b1;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_q       <= blank_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign red         = rgb_q.r;
   assign green       = rgb_q.g;
   assign blue        = rgb_q.b;
   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - scoreboard bench for video_timing_ctrl
module tb_video_timing_ctrl;

   typedef struct packed {
      logic       blank;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       uf;
      logic [8:0] rgb;
      logic       rdy;
      logic [3:0] x;
      logic [3:0] y;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, enable, pixel_valid, underflow_clr;
   logic [8:0] pixel_data;
   logic       pixel_ready, hsync, vsync, blank, frame_start, underflow;
   logic [3:0] x, y;
   logic [2:0] red, green, blue;

   logic       enable_d;
   logic       d_ready, d_hsync, d_vsync, d_blank, d_fs, d_uf;
   logic [9:0] d_x, d_y;
   logic [2:0] d_r, d_g, d_b;

   video_timing_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1), .CW(4)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .pixel_data(pixel_data),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .x(x), .y(y),
      .hsync(hsync), .vsync(vsync), .blank(blank), .red(red), .green(green),
      .blue(blue), .frame_start(frame_start), .underflow(underflow),
      .underflow_clr(underflow_clr)
   );

   video_timing_ctrl dut_vga (
      .clk(clk), .reset(reset), .enable(enable_d), .pixel_data(9'h1ff),
      .pixel_valid(1'b1), .pixel_ready(d_ready), .x(d_x), .y(d_y),
      .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank), .red(d_r), .green(d_g),
      .blue(d_b), .frame_start(d_fs), .underflow(d_uf), .underflow_clr(1'b0)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   logic chk_period = 1'b0;

   logic       run_m;
   logic [3:0] h_m, v_m;
   exp_t       ob;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      run_m    = 1'b0;
      h_m      = 4'd0;
      v_m      = 4'd0;
      ob       = '0;
      ob.blank = 1'b1;
   endtask

   // Small raster: H 8/2/3/2 (15 clocks), V 4/1/2/1 (8 lines), hsync h=10..12, vsync v=5..6
   task automatic step(input logic en, input logic vld, input logic clr);
      exp_t e, n;
      logic rdy;
      rdy   = run_m && (h_m < 4'd8) && (v_m < 4'd4);
      e     = ob;
      e.rdy = rdy;
      e.x   = rdy ? h_m : 4'd0;
      e.y   = rdy ? v_m : 4'd0;
      enable        = en;
      pixel_valid   = vld;
      underflow_clr = clr;
      pixel_data    = 9'(int'(e.x) + 16 * int'(e.y));
      q.push_back(e);
      n       = '0;
      n.blank = !rdy;
      n.hs    = run_m && (h_m >= 4'd10) && (h_m <= 4'd12);
      n.vs    = run_m && (v_m >= 4'd5) && (v_m <= 4'd6);
      n.rgb   = (rdy && vld) ? pixel_data : 9'd0;
      n.fs    = rdy && (h_m == 4'd0) && (v_m == 4'd0);
      n.uf    = (rdy && !vld) || (ob.uf && !clr);
      ob      = n;
      if (!run_m) begin
         run_m = en;
      end else begin
         if (h_m == 4'd14 && v_m == 4'd7 && !en) run_m = 1'b0;
         if (h_m == 4'd14) begin
            h_m = 4'd0;
            v_m = (v_m == 4'd7) ? 4'd0 : v_m + 4'd1;
         end else begin
            h_m = h_m + 4'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t mon_e, mon_a;
      int   cyc, last_fs, act;
      cyc = 0; last_fs = -1; act = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            act     = 0;
            last_fs = -1;
         end else begin
            if (q.size() > 0) begin
               mon_e       = q.pop_front();
               mon_a.blank = blank;
               mon_a.hs    = hsync;
               mon_a.vs    = vsync;
               mon_a.fs    = frame_start;
               mon_a.uf    = underflow;
               mon_a.rgb   = {red, green, blue};
               mon_a.rdy   = pixel_ready;
               mon_a.x     = x;
               mon_a.y     = y;
               chk("cycle", mon_a, mon_e);
            end
            if (!blank) begin
               act++;
            end else if (act != 0) begin
               chk("line_active", act, 8);
               act = 0;
            end
            if (!chk_period) begin
               last_fs = -1;
            end else if (frame_start) begin
               if (last_fs >= 0) chk("fs_period", cyc - last_fs, 120);
               last_fs = cyc;
            end
         end
      end
   end

   initial begin : stimulus
      int   frame;
      logic dropped, pend_px, pend_uf, en, vld, clr;
      int   hs_run, rise0, rise1, rdy_cnt, blank_lo, vs_cnt;
      logic hs_prev;

      reset = 1'b1; enable = 1'b0; pixel_valid = 1'b0; underflow_clr = 1'b0;
      pixel_data = 9'd0; enable_d = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      repeat (50) step(1'b0, 1'b1, 1'b0);

      // three back-to-back frames: underflow in frame 1, enable dropped mid frame 3
      frame = 0; dropped = 1'b0; pend_px = 1'b0; pend_uf = 1'b0;
      chk_period = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 365; n++) begin
         if (pend_px) chk("rgb_at_1_2", {red, green, blue}, 9'h021);
         if (pend_uf) chk("uf_black_set", {underflow, red, green, blue}, {1'b1, 9'h000});
         pend_px = 1'b0;
         pend_uf = 1'b0;
         if (run_m && h_m == 4'd0 && v_m == 4'd0) frame++;
         if (run_m && frame == 3 && h_m == 4'd5 && v_m == 4'd2) dropped = 1'b1;
         en  = !dropped;
         vld = !(run_m && frame == 1 && h_m == 4'd3 && v_m == 4'd1);
         clr = run_m && frame == 1 && ((h_m == 4'd3 && v_m == 4'd1) || (h_m == 4'd5 && v_m == 4'd3));
         pend_px = run_m && frame == 1 && h_m == 4'd1 && v_m == 4'd2;
         pend_uf = !vld;
         step(en, vld, clr);
      end
      chk_period = 1'b0;
      chk("frames_run", frame, 3);

      // asynchronous reset in the middle of a frame
      step(1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 200 && !(run_m && h_m == 4'd6 && v_m == 4'd3); n++) begin
         step(1'b1, 1'b1, 1'b0);
      end
      chk("reach_6_3", {pixel_ready, x, y}, {1'b1, 4'd6, 4'd3});
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset",
          {pixel_ready, x, y, blank, hsync, vsync, red, green, blue, frame_start, underflow},
          {1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      repeat (3) step(1'b0, 1'b1, 1'b0);
      repeat (126) step(1'b1, 1'b1, 1'b0);

      // default 640x480 timing: first two lines
      enable_d = 1'b1;
      hs_run = 0; rise0 = -1; rise1 = -1; rdy_cnt = 0; blank_lo = 0; vs_cnt = 0;
      hs_prev = 1'b0;
      for (int i = 0; i < 1600; i++) begin
         @(posedge clk);
         #1;
         if (d_ready) rdy_cnt++;
         if (!d_blank) blank_lo++;
         if (d_vsync) vs_cnt++;
         if (d_hsync) begin
            if (!hs_prev) begin
               if (rise0 < 0) rise0 = i;
               else rise1 = i;
            end
            hs_run++;
         end else if (hs_prev) begin
            chk("vga_hsync_width", hs_run, 96);
            hs_run = 0;
         end
         hs_prev = d_hsync;
      end
      chk("vga_line_period", rise1 - rise0, 800);
      chk("vga_hsync_first", rise0, 657);
      chk("vga_ready_cnt", rdy_cnt, 1280);
      chk("vga_active_out", blank_lo, 1280);
      chk("vga_vsync_idle", vs_cnt, 0);

      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Generates the raster timing that drives the TMDS encoder/serialiser: hsync, vsync, blank and 3-bit-per-channel colour, all registered and mutually aligned. Pulls pixels from an upstream pixel source (framebuffer read port or pattern generator) with a valid/ready handshake during active video. Sits between the pixel source and the DVI output block. Runs entirely in the pixel clock domain.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 1, asserted level of hsync/vsync
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high
- enable  in  1  run request; sampled only at frame boundaries
- pixel_data  in  9  {red[2:0], green[2:0], blue[2:0]}
- pixel_valid  in  1  pixel_data valid
- pixel_ready  out  1  controller consumes a pixel this cycle
- x  out  CW  column of the pixel being requested (valid while pixel_ready)
- y  out  CW  line of the pixel being requested (valid while pixel_ready)
- hsync, vsync, blank  out  1 each  to the DVI output block
- red, green, blue  out  3 each  to the DVI output block
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)
- underflow  out  1  sticky: pixel needed but pixel_valid low
- underflow_clr  in  1  clears underflow

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Top FSM: IDLE -> RUN when enable=1 in IDLE. RUN -> IDLE when enable=0 at the last clock of a frame (h=H_TOTAL-1, v=V_TOTAL-1). Deasserting enable mid-frame always completes the current frame.
- IDLE: h=v=0 held, pixel_ready=0, blank=1, syncs inactive (~SYNC_POL), rgb=0.
- RUN: h increments each clock and wraps H_TOTAL-1 -> 0. v increments on h wrap and wraps V_TOTAL-1 -> 0.
- Per-axis phase, decoded from the counter: ACTIVE [0, ACTIVE-1], FP, SYNC [ACTIVE+FP, ACTIVE+FP+SYNC-1], BP.
- hsync depends on h only; vsync depends on v only. There is no half-line offset.
- pixel_ready = RUN and h<H_ACTIVE and v<V_ACTIVE. This is combinational from the state registers; it must not depend on pixel_valid.
- x=h and y=v while pixel_ready; both are 0 otherwise.
- Transfer on pixel_ready & pixel_valid: the output rgb takes pixel_data.
- pixel_ready & !pixel_valid: output rgb = 0 (black), underflow set. The raster never stalls.
- Blank cycles: rgb = 0 regardless of pixel_data.
- Underflow priority: same-cycle set and underflow_clr -> set wins.

## Timing
- All outputs except pixel_ready/x/y are registered. They are one clock after the counter state that produced them, mutually aligned.
- frame_start is asserted with the registered output of (h,v)=(0,0), i.e. one clock after pixel_ready first rises in a frame.
- Reset values: hsync=vsync=~SYNC_POL, blank=1, rgb=0, frame_start=0, underflow=0, pixel_ready=0, x=y=0, FSM=IDLE.
- Reset asserted mid-frame forces all of the above immediately (asynchronous). Restart requires enable in IDLE.
- First RUN clock has h=v=0, so pixel_ready rises on the clock after the IDLE->RUN transition.

## Structure
- Shared package video_pkg holds:
  - default 640x480@60 timing constants;
  - FSM state typedef (IDLE, RUN);
  - axis-phase typedef (ACTIVE, FP, SYNC, BP);
  - packed pixel type {r,g,b}.
- Sub-module video_axis_counter: counter plus phase decode, parameterised by ACTIVE/FP/SYNC/BP. It has count-enable in, wrap pulse out, and count/phase/sync outputs. It is instantiated twice; the horizontal wrap pulse drives the vertical count-enable.

## Test plan
Small timing for all tests: H 8/2/3/2 (H_TOTAL 15), V 4/1/2/1 (V_TOTAL 8), SYNC_POL=1.
- Reset, enable=0 for 50 clocks -> blank=1, hsync=vsync=0, pixel_ready=0, rgb=0 throughout.
- enable=1, pixel_valid=1, pixel_data=x+16*y:
  - frame_start every 120 clocks;
  - per line, blank low for exactly 8 clocks;
  - hsync high at h=10..12 (seen one clock later);
  - vsync high for v=5..6;
  - rgb at output (1,2) equals 9'h021.
- pixel_valid=0 for one cycle at (3,1) -> that output pixel is black and underflow=1. underflow_clr in the same cycle as the fault -> underflow stays 1. A later clear with no fault -> 0.
- enable dropped at (5,2) -> frame completes. FSM enters IDLE after (14,7), and the next output cycle shows blank=1 and syncs low.
- Reset asserted at (6,3) -> outputs take reset values within the same clock, FSM is IDLE, and restart is clean on the next enable.
- Default 640x480 parameters, one full frame -> 420000 clocks per frame, 307200 transfers, hsync pulse 96 clocks, vsync 1600 clocks.
